// File: rtl/obc_shift_accumulator.sv
// Bit-serial OBC distributed-arithmetic accumulator: one ROM partial-sum word group per cycle,
// LSB first, with the MSB term subtracted (offset-binary) to form the final 35-bit result.
module obc_shift_accumulator #(
    parameter int W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dinit,
    input  logic [31:0] rom_in0,
    input  logic [31:0] rom_in1,
    input  logic [31:0] rom_in2,
    input  logic [31:0] rom_in3,
    output logic [4:0]  bit_idx,
    output logic        busy,
    output logic [34:0] result,
    output logic        out_valid,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [4:0] LAST_BIT = 5'(W - 1);

    // Handshake: start is a level sampled only while idle; out_valid is a one-cycle strobe
    // and result stays stable until the next completed operation overwrites it.

    logic [1:0]  state_q, state_d;
    logic [34:0] acc_q, acc_d;
    logic [34:0] result_q, result_d;
    logic [4:0]  bit_idx_q, bit_idx_d;

    logic [34:0] d_sum;
    logic [35:0] acc_plus_d;

    function automatic logic [34:0] sext35(input logic [31:0] v);
        return {{3{v[31]}}, v};
    endfunction

    // Sum kept one bit wider so the arithmetic shift never loses the carry.
    always_comb begin
        d_sum      = sext35(rom_in0) + sext35(rom_in1) + sext35(rom_in2) + sext35(rom_in3);
        acc_plus_d = {acc_q[34], acc_q} + {d_sum[34], d_sum};
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        result_d  = result_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d     = sext35(dinit);
                    bit_idx_d = 5'd0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (bit_idx_q == LAST_BIT) begin
                    acc_d    = acc_q - d_sum;
                    result_d = acc_q - d_sum;
                    state_d  = S_DONE;
                end else begin
                    acc_d     = acc_plus_d[35:1];
                    bit_idx_d = bit_idx_q + 5'd1;
                end
            end
            S_DONE: begin
                bit_idx_d = 5'd0;
                state_d   = S_IDLE;
            end
            default: begin
                bit_idx_d = 5'd0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            result_q  <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign bit_idx   = bit_idx_q;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Bench for obc_shift_accumulator: three instances (W=4, 2, 16) sharing data inputs,
// directed vector table, hand-written busy/reset sequences and a random run against a model.
module tb_obc_shift_accumulator;

    logic        clk;
    logic        rst;
    logic        start_v [3];
    logic [31:0] dinit;
    logic [31:0] rom_in0, rom_in1, rom_in2, rom_in3;
    logic [4:0]  bidx [3];
    logic        bsy [3];
    logic [34:0] res [3];
    logic        ov [3];
    logic [1:0]  dbg [3];

    int          sel;
    int          wv [3];
    logic [31:0] rom_tab [32][4];
    int          n_chk;
    int          n_fail;

    obc_shift_accumulator #(.W(4)) u_w4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .dinit(dinit),
        .rom_in0(rom_in0), .rom_in1(rom_in1), .rom_in2(rom_in2), .rom_in3(rom_in3),
        .bit_idx(bidx[0]), .busy(bsy[0]), .result(res[0]), .out_valid(ov[0]), .dbg_state(dbg[0]));

    obc_shift_accumulator #(.W(2)) u_w2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .dinit(dinit),
        .rom_in0(rom_in0), .rom_in1(rom_in1), .rom_in2(rom_in2), .rom_in3(rom_in3),
        .bit_idx(bidx[1]), .busy(bsy[1]), .result(res[1]), .out_valid(ov[1]), .dbg_state(dbg[1]));

    obc_shift_accumulator #(.W(16)) u_w16 (
        .clk(clk), .rst(rst), .start(start_v[2]), .dinit(dinit),
        .rom_in0(rom_in0), .rom_in1(rom_in1), .rom_in2(rom_in2), .rom_in3(rom_in3),
        .bit_idx(bidx[2]), .busy(bsy[2]), .result(res[2]), .out_valid(ov[2]), .dbg_state(dbg[2]));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // combinational ROM stand-in, addressed by the selected instance's bit_idx
    always_comb begin
        rom_in0 = rom_tab[bidx[sel]][0];
        rom_in1 = rom_tab[bidx[sel]][1];
        rom_in2 = rom_tab[bidx[sel]][2];
        rom_in3 = rom_tab[bidx[sel]][3];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, expv);
        end
    endtask

    // reference: LSB-first shift-accumulate, final MSB term subtracted, full-width integers
    function automatic logic [34:0] model(input int w, input logic [31:0] di);
        longint acc;
        longint d;
        acc = longint'(signed'(di));
        for (int b = 0; b < w; b++) begin
            d = 0;
            for (int k = 0; k < 4; k++) d += longint'(signed'(rom_tab[b][k]));
            if (b < w - 1) acc = (acc + d) >>> 1;
            else           acc = acc - d;
        end
        return acc[34:0];
    endfunction

    task automatic fill_const(input logic [31:0] lo [4], input logic [31:0] hi [4]);
        for (int b = 0; b < 32; b++)
            for (int k = 0; k < 4; k++)
                rom_tab[b][k] = (b == 0) ? lo[k] : hi[k];
    endtask

    // called at a negedge with the instance idle; returns at the negedge of the following IDLE cycle
    task automatic run_op(input int i, input logic [31:0] di, input logic [34:0] expv, input string nm);
        int cyc;
        sel        = i;
        dinit      = di;
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        dinit      = $urandom;
        chk({nm, "_busy_run"}, 64'(bsy[i]), 64'd1);
        cyc = 0;
        while (!ov[i] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_valid_seen"}, 64'(ov[i]), 64'd1);
        chk({nm, "_latency"}, 64'(cyc), 64'(wv[i]));
        chk({nm, "_result"}, 64'(res[i]), 64'(expv));
        @(negedge clk);
        chk({nm, "_valid_pulse"}, 64'(ov[i]), 64'd0);
        chk({nm, "_idle_busy"}, 64'(bsy[i]), 64'd0);
        chk({nm, "_idle_bidx"}, 64'(bidx[i]), 64'd0);
    endtask

    typedef struct {
        string       nm;
        int          inst;
        logic [31:0] di;
        logic [31:0] lo [4];
        logic [31:0] hi [4];
        logic [34:0] expv;
    } vec_t;

    vec_t vt [5];

    initial begin
        int          pulsed;
        int          ov_cnt;
        int          cyc;
        logic [34:0] hold_val;
        logic [31:0] di;
        int          mode;

        n_chk  = 0;
        n_fail = 0;
        wv[0] = 4; wv[1] = 2; wv[2] = 16;
        sel   = 0;
        dinit = '0;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        for (int b = 0; b < 32; b++)
            for (int k = 0; k < 4; k++) rom_tab[b][k] = '0;

        vt[0] = '{"const_d",   0, 32'h0,   '{32'h100, 0, 0, 0}, '{32'h100, 0, 0, 0}, 35'h7FFFFFFE0};
        vt[1] = '{"init_only", 0, 32'h800, '{0, 0, 0, 0},       '{0, 0, 0, 0},       35'd256};
        vt[2] = '{"trunc_pos", 1, 32'h0,   '{32'd3, 0, 0, 0},   '{32'd3, 0, 0, 0},   35'h7FFFFFFFE};
        vt[3] = '{"trunc_neg", 1, 32'h0,   '{32'hFFFFFFFD, 0, 0, 0}, '{0, 0, 0, 0},  35'h7FFFFFFFE};
        vt[4] = '{"full_range", 1, 32'h0,
                  '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000},
                  '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000}, 35'h100000000};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_result_%0d", i), 64'(res[i]), 64'd0);
            chk($sformatf("reset_busy_%0d", i), 64'(bsy[i]), 64'd0);
            chk($sformatf("reset_valid_%0d", i), 64'(ov[i]), 64'd0);
            chk($sformatf("reset_bidx_%0d", i), 64'(bidx[i]), 64'd0);
        end

        // directed vectors, issued back-to-back
        for (int v = 0; v < 5; v++) begin
            fill_const(vt[v].lo, vt[v].hi);
            run_op(vt[v].inst, vt[v].di, vt[v].expv, vt[v].nm);
        end

        // idle hold: result must not move while start is low
        hold_val = res[1];
        repeat (4) @(negedge clk);
        chk("idle_hold_result", 64'(res[1]), 64'(hold_val));
        chk("idle_hold_bidx", 64'(bidx[1]), 64'd0);

        // start pulsed again mid-run with a different dinit
        fill_const(vt[0].lo, vt[0].hi);
        sel        = 0;
        dinit      = 32'h0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        pulsed = 0;
        ov_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            start_v[0] = 1'b0;
            if (bidx[0] == 5'd2 && bsy[0] && pulsed == 0) begin
                start_v[0] = 1'b1;
                dinit      = 32'h800;
                pulsed     = 1;
            end
            @(negedge clk);
            if (pulsed == 1) begin
                chk("busy_restart_busy", 64'(bsy[0]), 64'd1);
                pulsed = 2;
            end
            if (ov[0]) ov_cnt++;
        end
        start_v[0] = 1'b0;
        chk("busy_restart_pulsed", 64'(pulsed), 64'd2);
        chk("busy_restart_valid_count", 64'(ov_cnt), 64'd1);
        chk("busy_restart_result", 64'(res[0]), 64'h7FFFFFFE0);

        // reset mid-run, then an immediate new start
        fill_const(vt[1].lo, vt[1].hi);
        run_op(0, 32'h800, 35'd256, "pre_abort");
        fill_const(vt[0].lo, vt[0].hi);
        dinit      = 32'h0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cyc = 0;
        while (bidx[0] != 5'd1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_bit1", 64'(bidx[0]), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(bsy[0]), 64'd0);
        chk("abort_result", 64'(res[0]), 64'd0);
        chk("abort_valid", 64'(ov[0]), 64'd0);
        run_op(0, 32'h0, 35'h7FFFFFFE0, "after_abort");

        // randomized runs against the reference model
        for (int r = 0; r < 16; r++) begin
            mode = $urandom_range(0, 2);
            for (int b = 0; b < 32; b++)
                for (int k = 0; k < 4; k++)
                    rom_tab[b][k] = (mode == 0) ? 32'($urandom_range(0, 4000)) - 32'd2000 : $urandom;
            di = (mode == 2) ? $urandom : 32'($urandom_range(0, 100000)) - 32'd50000;
            if (r % 4 == 3) run_op(0, di, model(4, di), $sformatf("rand_w4_%0d", r));
            else            run_op(2, di, model(16, di), $sformatf("rand_w16_%0d", r));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
